// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM states, response codes and
// the default window of the downstream memory slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_BASE_ADDR = 32'hA200_0000;
  localparam int          DEF_MEM_WORDS = 16;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational window decode: flags a hit on [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS)
// and produces the word index inside the window.
module apb_addr_decode #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = apb_pkg::DEF_BASE_ADDR,
  parameter int                    MEM_WORDS  = apb_pkg::DEF_MEM_WORDS
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] word_idx
);

  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

  logic [ADDR_WIDTH-1:0] off;

  assign off      = addr - BASE_ADDR;
  // The >= guard rejects addresses below the base whose offset wrapped around.
  assign hit      = (addr >= BASE_ADDR) && (off < WIN_BYTES);
  assign word_idx = {2'b00, off[ADDR_WIDTH-1:2]};

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on APB,
// valid/ready response out, with local DECERR for misses and a wait-state timeout.
module apb_master_bridge #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DATA_STRB   = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = apb_pkg::DEF_BASE_ADDR,
  parameter int                    MEM_WORDS   = apb_pkg::DEF_MEM_WORDS,
  parameter int                    TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_STRB-1:0]  req_strb,
  input  logic [2:0]            req_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [2:0]            pprot,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_STRB-1:0]  pstrb,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);
  import apb_pkg::*;

  localparam int              CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  apb_state_t            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  dec_hit;
  logic [ADDR_WIDTH-1:0] dec_idx;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .MEM_WORDS  (MEM_WORDS)
  ) u_decode (
    .addr     (req_addr),
    .hit      (dec_hit),
    .word_idx (dec_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= RESP_OKAY;
      paddr     <= '0;
      pprot     <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            if (dec_hit) begin
              state    <= SETUP;
              psel     <= 1'b1;
              penable  <= 1'b0;
              paddr    <= dec_idx;
              pwrite   <= req_write;
              pprot    <= req_prot;
              pwdata   <= req_write ? req_wdata : '0;
              pstrb    <= req_write ? req_strb : '0;
              wait_cnt <= '0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= RESP_DECERR;
              rsp_rdata <= '0;
            end
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end

        ACCESS: begin
          if (pready) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr ? RESP_SLVERR : RESP_OKAY;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // A stalled slave is abandoned once the TIMEOUT_CYC-th idle cycle ends.
            if ((TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST)) begin
              state     <= RESP;
              psel      <= 1'b0;
              penable   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= RESP_SLVERR;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench: stub APB slave, transaction-level reference model and a
// per-cycle compare process, driven by directed cases plus random traffic.
module tb_apb_master_bridge;

  localparam int              AW    = 32;
  localparam int              DW    = 32;
  localparam int              SW    = 4;
  localparam longint unsigned BASE  = 64'hA200_0000;
  localparam int              WORDS = 16;
  localparam int              TMO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strb = '0;
  logic [2:0]    req_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DATA_STRB (SW),
    .BASE_ADDR (32'hA200_0000), .MEM_WORDS (WORDS), .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
    .req_write (req_write), .req_wdata (req_wdata), .req_strb (req_strb),
    .req_prot (req_prot),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_err (rsp_err),
    .paddr (paddr), .pprot (pprot), .pwrite (pwrite), .psel (psel),
    .penable (penable), .pwdata (pwdata), .pstrb (pstrb),
    .pready (pready), .pslverr (pslverr), .prdata (prdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stub slave: cur_ws wait states, optional error, optional permanent stall.
  int          cur_ws    = 0;
  bit          cur_err   = 1'b0;
  bit          cur_stall = 1'b0;
  int          wcnt      = 0;
  logic [31:0] smem   [WORDS];
  logic [31:0] shadow [WORDS];

  always_comb pready  = psel && penable && !cur_stall && (wcnt == cur_ws);
  always_comb pslverr = pready && cur_err;
  always_comb prdata  = (psel && !pslverr) ? smem[paddr[3:0]] : '0;

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (pready && pwrite && !pslverr)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) smem[paddr[3:0]][b*8 +: 8] <= pwdata[b*8 +: 8];
  end

  typedef struct {
    bit          hit;
    logic [31:0] idx;
    logic        wr;
    logic [2:0]  prot;
    logic [31:0] wd;
    logic [3:0]  st;
    int          dur;
    logic [31:0] rd;
    logic [1:0]  err;
  } exp_t;

  // Transaction-level reference: outcome of one command given the slave setup.
  function automatic exp_t predict(input logic [31:0] addr, input logic w,
                                   input logic [31:0] d, input logic [3:0] s,
                                   input logic [2:0] p);
    exp_t r;
    longint unsigned a = addr;
    r.hit  = (a >= BASE) && (a < BASE + WORDS * 4);
    r.idx  = r.hit ? 32'((a - BASE) / 4) : 32'd0;
    r.wr   = w;
    r.prot = p;
    r.wd   = w ? d : 32'd0;
    r.st   = w ? s : 4'd0;
    r.dur  = 0;
    r.rd   = 32'd0;
    if (!r.hit) begin
      r.err = 2'b11;
    end else if (cur_stall) begin
      r.dur = TMO;
      r.err = 2'b10;
    end else begin
      r.dur = cur_ws + 1;
      if (cur_err) begin
        r.err = 2'b10;
      end else begin
        r.err = 2'b00;
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) shadow[r.idx[3:0]][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          r.rd = shadow[r.idx[3:0]];
        end
      end
    end
    return r;
  endfunction

  bit          busy = 1'b0;
  bit          post_done = 1'b0;
  int          cyc = 0, acc_cnt = 0, rsp_first = 0, done_cnt = 0;
  int          cycle_no = 0, hs_cyc = 0, acc_cyc = 0;
  int          last_acc = 0, last_rsp_first = 0;
  logic [31:0] seen_paddr = '0, last_rdata = '0;
  logic [1:0]  last_err = '0;
  exp_t        e;

  // Compare process: every cycle, DUT outputs against the model's expectations.
  initial forever begin
    @(negedge clk);
    cycle_no++;
    if (rst) begin
      busy      = 1'b0;
      post_done = 1'b0;
    end else begin
      if (post_done) begin
        chk("ready_after_rsp", req_ready, 1);
        post_done = 1'b0;
      end
      if (busy) begin
        cyc++;
        chk("busy_not_ready", req_ready, 0);
        if (!e.hit || cyc >= 2 + e.dur) begin
          if (rsp_first == 0) rsp_first = cyc;
          chk("rsp_psel", psel, 0);
          chk("rsp_penable", penable, 0);
          chk("rsp_valid", rsp_valid, 1);
          chk("rsp_rdata", rsp_rdata, e.rd);
          chk("rsp_err", rsp_err, e.err);
          if (rsp_ready) begin
            busy = 1'b0;
            post_done = 1'b1;
            hs_cyc = cycle_no;
            last_rdata = rsp_rdata;
            last_err = rsp_err;
            last_acc = acc_cnt;
            last_rsp_first = rsp_first;
            done_cnt++;
          end
        end else begin
          chk("apb_psel", psel, 1);
          chk("apb_penable", penable, cyc >= 2);
          chk("apb_paddr", paddr, e.idx);
          chk("apb_pwrite", pwrite, e.wr);
          chk("apb_pprot", pprot, e.prot);
          chk("apb_pwdata", pwdata, e.wd);
          chk("apb_pstrb", pstrb, e.st);
          chk("apb_no_rsp", rsp_valid, 0);
          if (cyc == 1) seen_paddr = paddr;
          if (cyc >= 2) acc_cnt++;
        end
      end else begin
        chk("idle_psel", psel, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
      end
      if (!busy && req_valid && req_ready) begin
        e = predict(req_addr, req_write, req_wdata, req_strb, req_prot);
        busy = 1'b1;
        cyc = 0;
        acc_cnt = 0;
        rsp_first = 0;
        seen_paddr = '1;
        acc_cyc = cycle_no;
      end
    end
  end

  task automatic present(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_strb  = s;
    req_prot  = p;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int dly);
    int start = done_cnt;
    bit ok = 1'b0;
    rsp_ready = (dly == 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rsp_wait_timeout", ok, 1);
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rsp_handshake_timeout", ok, 1);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p, input int dly);
    present(a, w, d, s, p);
    wait_accept();
    req_valid = 1'b0;
    drain(dly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k;
    logic [31:0] a;
    for (int i = 0; i < WORDS; i++) begin
      smem[i]   = '0;
      shadow[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_rsp_err", rsp_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Write then read back through the slave, zero wait states.
    do_xfer(32'hA200_0008, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd2, 0);
    chk("wr_paddr", seen_paddr, 2);
    chk("wr_err", last_err, 2'b00);
    chk("wr_latency", last_rsp_first, 3);
    do_xfer(32'hA200_0008, 1'b0, 32'h0, 4'h0, 3'd0, 0);
    chk("rd_paddr", seen_paddr, 2);
    chk("rd_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd_err", last_err, 2'b00);
    chk("rd_latency", last_rsp_first, 3);

    // First address past the window.
    do_xfer(32'hA200_0040, 1'b0, 32'h0, 4'h0, 3'd0, 1);
    chk("miss_err", last_err, 2'b11);
    chk("miss_rdata", last_rdata, 0);
    chk("miss_latency", last_rsp_first, 1);
    chk("miss_no_access", last_acc, 0);

    // Stalled slave forces the timeout.
    cur_stall = 1'b1;
    do_xfer(32'hA200_0004, 1'b0, 32'h0, 4'h0, 3'd0, 0);
    cur_stall = 1'b0;
    chk("timeout_access_cycles", last_acc, 16);
    chk("timeout_err", last_err, 2'b10);

    // Three wait states then slave error.
    cur_ws = 3;
    cur_err = 1'b1;
    do_xfer(32'hA200_000C, 1'b1, 32'h1234_5678, 4'h3, 3'd5, 0);
    cur_ws = 0;
    cur_err = 1'b0;
    chk("wait_access_cycles", last_acc, 4);
    chk("slverr_err", last_err, 2'b10);

    // Response back-pressure with the next command already waiting.
    present(32'hA200_0008, 1'b0, 32'h0, 4'h0, 3'd1);
    wait_accept();
    present(32'hA200_003C, 1'b1, 32'hCAFE_F00D, 4'hF, 3'd3);
    drain(5);
    chk("bp_rdata", last_rdata, 32'hDEAD_BEEF);
    wait_accept();
    req_valid = 1'b0;
    chk("bp_next_accept_gap", acc_cyc - hs_cyc, 1);
    drain(0);
    chk("bp_second_paddr", seen_paddr, 15);

    // Reset in the middle of ACCESS.
    cur_stall = 1'b1;
    present(32'hA200_0004, 1'b0, 32'h0, 4'h0, 3'd0);
    wait_accept();
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cur_stall = 1'b0;
    do_xfer(32'hA200_0008, 1'b0, 32'h0, 4'h0, 3'd0, 0);
    chk("postrst_err", last_err, 2'b00);
    chk("postrst_rdata", last_rdata, 32'hDEAD_BEEF);

    // Random traffic against the model.
    for (int t = 0; t < 80; t++) begin
      k = int'($urandom_range(0, 9));
      if (k < 7)       a = 32'hA200_0000 + 32'(4 * $urandom_range(0, 15));
      else if (k == 7) a = 32'hA200_0040 + 32'(4 * $urandom_range(0, 3));
      else if (k == 8) a = 32'hA1FF_FFFC;
      else             a = $urandom;
      cur_ws    = int'($urandom_range(0, 3));
      cur_err   = ($urandom_range(0, 7) == 0);
      cur_stall = ($urandom_range(0, 15) == 0);
      do_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)),
              3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end
    cur_stall = 1'b0;
    cur_err   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that feeds the APB memory slave: accepts one word-access command on a valid/ready request channel, runs the APB SETUP/ACCESS sequence, and returns the read data and status on a valid/ready response channel.
- Performs window decode against the slave's base address; out-of-window accesses are answered locally without touching APB.
- Adds a wait-state timeout so a stalled slave cannot hang the requester.

Parameters:
- ADDR_WIDTH, 32, request and APB address width.
- DATA_WIDTH, 32, data width.
- DATA_STRB, DATA_WIDTH/8, strobe width.
- BASE_ADDR, 32'hA200_0000, byte base of the slave window.
- MEM_WORDS, 16, window size in words.
- TIMEOUT_CYC, 16, max ACCESS cycles with pready low (0 disables timeout).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high with req_valid.
- req_addr  in  ADDR_WIDTH  byte address.
- req_write  in  1  1=write, 0=read.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_STRB  byte strobes.
- req_prot  in  3  protection attributes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors).
- rsp_err  out  2  00 OKAY, 10 SLVERR (slave error or timeout), 11 DECERR.
- paddr  out  ADDR_WIDTH  APB word index.
- pprot  out  3  APB prot.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_STRB  APB strobes.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.
- prdata  in  DATA_WIDTH  slave read data.

Behaviour:
- Reset (async): state IDLE; psel, penable, rsp_valid = 0; all other outputs 0; timeout counter 0. Reset mid-transfer drops psel/penable immediately and discards the command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1 only in IDLE.
  - On handshake, capture the command.
  - Decode: off = req_addr - BASE_ADDR. Hit if req_addr >= BASE_ADDR and off < MEM_WORDS*4.
  - Hit -> SETUP. Miss -> RESP with rsp_err = 11 and rsp_rdata = 0; no APB activity.
- SETUP (one cycle):
  - psel = 1, penable = 0.
  - paddr = off >> 2 (word index, upper bits zero).
  - pwrite and pprot from the command.
  - Writes: pwdata/pstrb from the command. Reads: pwdata = 0, pstrb = 0.
  - Unconditionally -> ACCESS.
- ACCESS:
  - psel = 1, penable = 1; all APB outputs held stable.
  - pready = 1: capture prdata (reads only, else 0), rsp_err = pslverr ? 10 : 00; -> RESP.
  - pready = 0: timeout counter increments. When TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC, abandon the transfer with rsp_err = 10 and rsp_rdata = 0; -> RESP.
  - Counter clears on every entry to SETUP.
- RESP:
  - psel = penable = 0; rsp_valid = 1.
  - rsp_rdata and rsp_err held stable until rsp_ready; on rsp_ready -> IDLE.
- Latency (zero-wait slave): request accepted at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid high from cycle N+3. Peak throughput is one transfer per 4 cycles.
- Commands are never reordered or dropped. Only one transfer is outstanding at a time.

Decomposition:
- Shared package apb_pkg:
  - State enum (IDLE/SETUP/ACCESS/RESP).
  - Response code constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - BASE_ADDR and MEM_WORDS defaults.
- One natural sub-module, apb_addr_decode: combinational window hit plus word-index generation, reusable by future multi-slave decoders.

Test Plan:
- Write req_addr=A200_0008, wdata=DEADBEEF, strb=F, then read the same address against the memory slave -> paddr=2 on both transfers; read rsp_rdata=DEADBEEF, rsp_err=00; rsp_valid at N+3.
- Read req_addr=A200_0040 (first address past window) -> psel never asserts; rsp_valid next cycle with rsp_err=11, rsp_rdata=0.
- Stub slave holding pready=0 with TIMEOUT_CYC=16 -> ACCESS lasts exactly 16 cycles, then psel drops; rsp_err=10.
- Stub slave inserting 3 wait states with pslverr=1 on completion -> APB outputs stable all 4 ACCESS cycles; rsp_err=10.
- rsp_ready held low 5 cycles with req_valid continuously high -> req_ready stays 0, response held stable; next SETUP starts one cycle after the rsp handshake.
- Assert rst during ACCESS -> psel/penable/rsp_valid go 0 asynchronously; after release, a new read completes normally with rsp_err=00.
